dpu_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one single-ported data-memory bank of the DAG processing unit among `N_REQ` requesters (PE trees, load/store unit, host port). Accepts one access per cycle over a valid/ready handshake and drives the registered SRAM-side request. Routes read data back to the originating requester at a fixed latency. Optionally lets a requester lock the bank for a bounded burst. One instance per bank, sitting between the crossbar and the bank macro inside `pru_async_top`.

---
 rtl/dpu_arb_pkg.sv | 23 ++
 rtl/dpu_rr_pick.sv | 26 ++
 rtl/dpu_bank_arbiter.sv | 138 +++++++++++++
 tb/tb_dpu_bank_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_arb_pkg.sv
// dpu_arb_pkg: shared types, default parameters and helpers for the DPU bank arbiters.
package dpu_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 32;
    localparam int RD_LAT_DEF    = 1;
    localparam int MAX_BURST_DEF = 8;
    // Wide enough for up to 256 requesters; narrower ids are zero-extended.
    localparam int TRK_ID_W      = 8;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    typedef struct packed {
        logic                vld;
        logic [TRK_ID_W-1:0] id;
    } rd_track_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/dpu_rr_pick.sv
// dpu_rr_pick: combinational round-robin picker; first valid at index >= ptr_i, wrapping.
module dpu_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (valid_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/dpu_bank_arbiter.sv
// dpu_bank_arbiter: round-robin sharing of one single-ported DPU data bank with fixed-latency read return.
// Define DPU_ARB_LOCK_EN to honour req_lock bursts (ARB/LOCKED FSM capped at MAX_BURST beats).
module dpu_bank_arbiter
    import dpu_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = 1;

    logic [N_REQ-1:0]  pick_gnt, gnt;
    logic [IW-1:0]     pick_idx, gnt_idx, ptr_q, ptr_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, acc, rd_busy;
    rd_track_t         trk_q [RD_LAT+1];

    dpu_rr_pick #(.N(N_REQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx)
    );

    // Grant is held off while reset is asserted so no beat can be seen as accepted.
    assign req_ready = gnt & {N_REQ{rst}};
    assign acc       = |req_ready;
    assign ptr_d     = acc ? IW'(wrap_inc(int'(gnt_idx), N_REQ)) : ptr_q;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        rd_busy   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr  |= gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0;
            sel_wdata |= gnt[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
            sel_we    |= gnt[i] & req_we[i];
        end
        for (int i = 0; i <= RD_LAT; i++) rd_busy |= trk_q[i].vld;
    end

`ifdef DPU_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    arb_state_t    st_q, st_d;
    logic [IW-1:0] own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked, sel_lock;

    assign locked  = st_q == LOCKED;
    assign gnt     = locked ? req_valid & (ONE << own_q) : pick_gnt;
    assign gnt_idx = locked ? own_q : pick_idx;
    assign busy    = rd_busy | locked;

    // ptr_d already lands on owner+1 from the locking beat, so exit needs no pointer fixup.
    always_comb begin
        sel_lock = |(gnt & req_lock);
        st_d     = st_q;
        own_d    = own_q;
        cnt_d    = cnt_q;
        if (!locked) begin
            if (acc && sel_lock && MAX_BURST > 1) begin
                st_d  = LOCKED;
                own_d = gnt_idx;
                cnt_d = CW'(1);
            end
        end else if (!req_lock[own_q] || (acc && cnt_q + 1'b1 == CW'(MAX_BURST))) begin
            st_d  = ARB;
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= ARB;
            own_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            own_q <= own_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign gnt         = pick_gnt;
    assign gnt_idx     = pick_idx;
    assign busy        = rd_busy;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            for (int i = 0; i <= RD_LAT; i++) trk_q[i] <= '0;
        end else begin
            ptr_q     <= ptr_d;
            mem_en    <= acc;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            // Stage 0 lines up with mem_*, stage RD_LAT with mem_rdata.
            trk_q[0]  <= '{vld: acc & ~sel_we, id: TRK_ID_W'(gnt_idx)};
            for (int i = 1; i <= RD_LAT; i++) trk_q[i] <= trk_q[i-1];
            rsp_valid <= trk_q[RD_LAT].vld ? ONE << trk_q[RD_LAT].id : '0;
            rsp_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dpu_bank_arbiter.sv
// tb_dpu_bank_arbiter: randomized bench with a behavioural arbiter/SRAM reference model.
module tb_dpu_bank_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RL = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0, req_we = '0, req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_en, mem_we, busy;

    dpu_bank_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = (r < 0) ? i : 99;
        return r;
    endfunction

    // Reference model: expected grant, SRAM contents and response schedule from the rules.
    typedef struct {int due; int id; logic [DW-1:0] data;} exp_t;
    exp_t          q[$];
    logic [DW-1:0] gm [1024];
    int            cyc = 0, ptr_m = 0, g;
    bit            model_on = 1, m_en = 0, m_we = 0, ex_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_busy", busy, 0);
            ptr_m = 0;
            m_en  = 0;
            q.delete();
        end else if (model_on) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            chk("ready", req_ready, g < 0 ? 64'd0 : 64'd1 << g);
            chk("mem_en", mem_en, m_en);
            if (m_en) begin
                chk("mem_we", mem_we, m_we);
                chk("mem_addr", mem_addr, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            ex_busy = 0;
            foreach (q[i]) if (q[i].due > cyc && q[i].due - RL - 1 <= cyc) ex_busy = 1;
            chk("busy", busy, ex_busy);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 64'd1 << q[0].id);
                chk("rsp_rdata", rsp_rdata, q[0].data);
                void'(q.pop_front());
            end else begin
                chk("rsp_valid", rsp_valid, 0);
            end
            m_en = g >= 0;
            if (g >= 0) begin
                m_we    = req_we[g];
                m_addr  = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                if (m_we) gm[m_addr] = m_wdata;
                else q.push_back('{due: cyc + RL + 2, id: g, data: gm[m_addr]});
                ptr_m = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic new_req(input int i, input bit rd_only);
        req_valid[i]           = rd_only || $urandom_range(0, 99) < 60;
        req_we[i]              = !rd_only && $urandom_range(0, 2) == 0;
        req_addr[i*AW +: AW]   = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
        req_wdata[i*DW +: DW]  = $urandom;
    endtask

    logic [N-1:0] done;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i] = '0;
            gm[i]   = '0;
        end
        sram[10'h010] = 32'hDEADBEEF;
        gm[10'h010]   = 32'hDEADBEEF;
        reset_dut();

        // Single read from req0.
        req_we = '0;
        req_addr[0 +: AW] = 10'h010;
        req_valid = 4'b0001;
        @(negedge clk); chk("sr_ready", req_ready, 4'b0001);
        tick(); req_valid = '0;
        @(negedge clk); chk("sr_mem_en", mem_en, 1); chk("sr_mem_addr", mem_addr, 10'h010);
        @(negedge clk); chk("sr_rsp_early", rsp_valid, 0);
        @(negedge clk); chk("sr_rsp_valid", rsp_valid, 4'b0001); chk("sr_rsp_data", rsp_rdata, 32'hDEADBEEF);

        // req2 writes 0x3FF, then req1 reads it back.
        tick();
        req_we = 4'b0100;
        req_addr[2*AW +: AW]  = 10'h3FF;
        req_wdata[2*DW +: DW] = 32'hA5A5A5A5;
        req_valid = 4'b0100;
        @(negedge clk); chk("wr_ready", req_ready, 4'b0100);
        tick();
        req_we = '0;
        req_addr[1*AW +: AW] = 10'h3FF;
        req_valid = 4'b0010;
        @(negedge clk); chk("wr_mem_we", mem_we, 1); chk("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("rd_ready", req_ready, 4'b0010);
        tick(); req_valid = '0;
        repeat (3) @(negedge clk);
        chk("wr_rd_valid", rsp_valid, 4'b0010); chk("wr_rd_data", rsp_rdata, 32'hA5A5A5A5);

        // Reset one cycle after accepting a read: nothing comes back.
        tick();
        req_addr[0 +: AW] = 10'h005;
        req_valid = 4'b0001;
        @(negedge clk); chk("mr_ready", req_ready, 4'b0001);
        tick(); req_valid = '0; rst = 1'b0;
        #1;
        chk("mr_mem_en", mem_en, 0); chk("mr_mem_addr", mem_addr, 0);
        chk("mr_rsp_valid", rsp_valid, 0); chk("mr_busy", busy, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();

        // Full contention from ptr=0.
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("contend", oh_idx(req_ready), i % N);
            done = req_valid & req_ready;
            tick();
            for (int r = 0; r < N; r++) if (done[r]) new_req(r, 1'b1);
        end

        // Random traffic honouring hold-until-ready.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            done = req_valid & req_ready;
            tick();
            for (int r = 0; r < N; r++) if (!req_valid[r] || done[r]) new_req(r, 1'b0);
        end
        req_valid = '0;
        repeat (8) tick();

`ifdef DPU_ARB_LOCK_EN
        model_on = 0;
        reset_dut();
        req_we = '0;
        req_valid = 4'b0001;
        @(negedge clk); chk("lk_pre", req_ready, 4'b0001);
        tick(); req_valid = 4'b1011; req_lock = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lk_burst", oh_idx(req_ready), i < 8 ? 1 : (i == 8 ? 3 : 0));
            tick();
        end
        req_valid = '0; req_lock = '0;
        reset_dut();
        req_valid = 4'b0010; req_lock = 4'b0010;
        @(negedge clk); chk("lk_grab", req_ready, 4'b0010);
        tick(); req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("lk_idle_ready", req_ready, 0); chk("lk_idle_busy", busy, 1);
            tick();
        end
        req_valid = '0; req_lock = '0;
        repeat (4) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
